// File: rtl/innerproduct_stream.sv
// innerproduct_stream: streaming inner product h' = sum x[i]*theta[i] over
// N_FEAT features, LANES features per beat, runtime-writable weight file,
// held result output with saturate or wrap arithmetic and sticky overflow.
module innerproduct_stream #(
  parameter int N_FEAT = 81,
  parameter int LANES  = 1,
  parameter int XW     = 7,
  parameter int TW     = 32,
  parameter int ACC_W  = 32,
  parameter int SAT    = 0,
  localparam int AW    = (N_FEAT > 1) ? $clog2(N_FEAT) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   w_we,
  input  logic [AW-1:0]          w_addr,
  input  logic [TW-1:0]          w_data,
  output logic                   w_busy,
  input  logic                   x_valid,
  output logic                   x_ready,
  input  logic [LANES*XW-1:0]    x_data,
  output logic                   y_valid,
  input  logic                   y_ready,
  output logic [ACC_W-1:0]       y_data,
  output logic                   y_ovf
);

  localparam int BEATS = (N_FEAT + LANES - 1) / LANES;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int PW    = XW + 1 + TW;
  localparam int SW    = ((ACC_W > PW) ? ACC_W : PW) + $clog2(LANES + 1) + 1;
  localparam logic [AW:0]      NF      = (AW + 1)'(N_FEAT);
  localparam logic [BW-1:0]    LAST    = BW'(BEATS - 1);
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic {S_ACC, S_HOLD} state_t;

  state_t                  state, state_nxt;
  logic [BW-1:0]           bcnt;
  logic [ACC_W-1:0]        acc;
  logic                    ovf_sticky;
  logic [TW-1:0]           theta [N_FEAT];

  logic signed [SW-1:0]    sum;
  logic signed [PW-1:0]    prod;
  logic [31:0]             idx;
  logic [SW-ACC_W:0]       sum_hi;
  logic                    ovf_now;
  logic [ACC_W-1:0]        acc_upd;
  logic                    ovf_upd;
  logic                    beat_acc;
  logic                    last_beat;
  logic                    w_commit;

  assign beat_acc  = x_valid & x_ready;
  assign last_beat = (bcnt == LAST);
  assign w_commit  = w_we & (state == S_ACC) & (bcnt == '0) & ({1'b0, w_addr} < NF);

  // Weight file: not reset, written only between vectors
  always_ff @(posedge clk) begin
    if (w_commit) theta[w_addr] <= w_data;
  end

  // Full-precision beat sum; padding lanes past N_FEAT contribute nothing
  always_comb begin
    sum  = {{(SW-ACC_W){acc[ACC_W-1]}}, acc};
    prod = '0;
    idx  = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      idx = 32'(bcnt) * 32'(LANES) + 32'(k);
      if (idx < 32'(N_FEAT)) begin
        prod = $signed({1'b0, x_data[k*XW +: XW]}) * $signed(theta[idx[AW-1:0]]);
        sum  = sum + SW'(prod);
      end
    end
  end

  // Range check against ACC_W, then clamp or wrap
  always_comb begin
    sum_hi  = sum[SW-1:ACC_W-1];
    ovf_now = (|sum_hi) & ~(&sum_hi);
    acc_upd = sum[ACC_W-1:0];
    if (ovf_now && (SAT != 0)) acc_upd = sum[SW-1] ? ACC_MIN : ACC_MAX;
    ovf_upd = ovf_sticky | ovf_now;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_ACC;
    else     state <= state_nxt;
  end

  // Next-state and handshake outputs
  always_comb begin
    state_nxt = state;
    x_ready   = 1'b0;
    y_valid   = 1'b0;
    w_busy    = (bcnt != '0);
    case (state)
      S_ACC: begin
        x_ready = 1'b1;
        if (beat_acc && last_beat) state_nxt = S_HOLD;
      end
      S_HOLD: begin
        y_valid = 1'b1;
        w_busy  = 1'b1;
        if (y_ready) state_nxt = S_ACC;
      end
      default: state_nxt = S_ACC;
    endcase
  end

  // Accumulator, beat counter and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcnt       <= '0;
      acc        <= '0;
      ovf_sticky <= 1'b0;
      y_data     <= '0;
      y_ovf      <= 1'b0;
    end else if (beat_acc) begin
      if (last_beat) begin
        y_data     <= acc_upd;
        y_ovf      <= ovf_upd;
        acc        <= '0;
        ovf_sticky <= 1'b0;
        bcnt       <= '0;
      end else begin
        acc        <= acc_upd;
        ovf_sticky <= ovf_upd;
        bcnt       <= bcnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_innerproduct_stream.sv
// Randomised self-checking bench for innerproduct_stream: a default-parameter
// instance (81 features, 32-bit wrap) and a small saturating 4-lane instance.
module tb_innerproduct_stream;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  // default instance
  logic        w_we = 1'b0;
  logic [6:0]  w_addr = '0;
  logic [31:0] w_data = '0;
  logic        w_busy;
  logic        x_valid = 1'b0;
  logic        x_ready;
  logic [6:0]  x_data = '0;
  logic        y_valid;
  logic        y_ready = 1'b0;
  logic [31:0] y_data;
  logic        y_ovf;

  // saturating instance: 10 features, 4 lanes, 16-bit
  logic        s_w_we = 1'b0;
  logic [3:0]  s_w_addr = '0;
  logic [15:0] s_w_data = '0;
  logic        s_w_busy;
  logic        s_x_valid = 1'b0;
  logic        s_x_ready;
  logic [27:0] s_x_data = '0;
  logic        s_y_valid;
  logic        s_y_ready = 1'b1;
  logic [15:0] s_y_data;
  logic        s_y_ovf;

  int n_checks = 0;
  int n_err    = 0;

  longint mth [81];
  longint sth [10];

  always #5 clk = ~clk;

  innerproduct_stream dut (
    .clk(clk), .rst(rst),
    .w_we(w_we), .w_addr(w_addr), .w_data(w_data), .w_busy(w_busy),
    .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data),
    .y_valid(y_valid), .y_ready(y_ready), .y_data(y_data), .y_ovf(y_ovf)
  );

  innerproduct_stream #(
    .N_FEAT(10), .LANES(4), .XW(7), .TW(16), .ACC_W(16), .SAT(1)
  ) dut_sat (
    .clk(clk), .rst(rst),
    .w_we(s_w_we), .w_addr(s_w_addr), .w_data(s_w_data), .w_busy(s_w_busy),
    .x_valid(s_x_valid), .x_ready(s_x_ready), .x_data(s_x_data),
    .y_valid(s_y_valid), .y_ready(s_y_ready), .y_data(s_y_data), .y_ovf(s_y_ovf)
  );

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // write the model weight array into the default instance
  task automatic load_main();
    for (int i = 0; i < 81; i++) begin
      w_we = 1'b1; w_addr = 7'(i); w_data = 32'(mth[i]);
      tick();
    end
    w_we = 1'b0;
  endtask

  task automatic load_sat();
    for (int i = 0; i < 10; i++) begin
      s_w_we = 1'b1; s_w_addr = 4'(i); s_w_data = 16'(sth[i]);
      tick();
    end
    s_w_we = 1'b0;
  endtask

  // one vector through the default instance; wrap arithmetic, per-feature
  // sticky overflow; optional write attempt during beat wr_beat and stall
  task automatic run_vec(input string tag, input longint xs[81], input bit stall,
                         input int wr_beat, input int wr_addr, input longint wr_val);
    longint acc = 0;
    longint s;
    bit     ovf = 1'b0;
    for (int b = 0; b < 81; b++) begin
      if ($urandom_range(0, 3) == 0) begin
        x_valid = 1'b0;
        tick();
      end
      x_valid = 1'b1;
      x_data  = 7'(xs[b]);
      if (b == 0)  check({tag, "_busy_b0"}, w_busy, 0);
      if (b == 10) check({tag, "_busy_b10"}, w_busy, 1);
      if (b == 80) check({tag, "_early_valid"}, y_valid, 0);
      if (b == wr_beat) begin
        w_we = 1'b1; w_addr = 7'(wr_addr); w_data = 32'(wr_val);
      end
      s = acc + xs[b] * mth[b];
      if (s > 64'sd2147483647 || s < -64'sd2147483648) ovf = 1'b1;
      acc = longint'(int'(s));
      if (b == wr_beat && b == 0) mth[wr_addr] = wr_val;
      tick();
      w_we = 1'b0;
    end
    x_valid = 1'b0;
    check({tag, "_y_valid"}, y_valid, 1);
    check({tag, "_x_ready_hold"}, x_ready, 0);
    check({tag, "_y_data"}, $signed(y_data), acc);
    check({tag, "_y_ovf"}, y_ovf, longint'(ovf));
    if (stall) begin
      w_we = 1'b1; w_addr = 7'd1; w_data = 32'd12345;
      for (int c = 0; c < 5; c++) begin
        tick();
        w_we = 1'b0;
        check({tag, "_stall_data"}, $signed(y_data), acc);
        check({tag, "_stall_x_ready"}, x_ready, 0);
        check({tag, "_stall_busy"}, w_busy, 1);
      end
    end
    y_ready = 1'b1;
    tick();
    y_ready = 1'b0;
    check({tag, "_y_valid_drop"}, y_valid, 0);
    check({tag, "_x_ready_back"}, x_ready, 1);
  endtask

  // one vector through the saturating instance; clamp per beat sum
  task automatic run_sat(input string tag, input longint xs[12]);
    longint acc = 0;
    longint s;
    bit     ovf = 1'b0;
    for (int b = 0; b < 3; b++) begin
      s_x_valid = 1'b1;
      for (int k = 0; k < 4; k++) s_x_data[k*7 +: 7] = 7'(xs[b*4+k]);
      s = acc;
      for (int k = 0; k < 4; k++)
        if (b*4 + k < 10) s = s + xs[b*4+k] * sth[b*4+k];
      if (s > 32767) begin ovf = 1'b1; acc = 32767; end
      else if (s < -32768) begin ovf = 1'b1; acc = -32768; end
      else acc = s;
      tick();
    end
    s_x_valid = 1'b0;
    check({tag, "_y_valid"}, s_y_valid, 1);
    check({tag, "_y_data"}, $signed(s_y_data), acc);
    check({tag, "_y_ovf"}, s_y_ovf, longint'(ovf));
    tick();
    check({tag, "_x_ready_back"}, s_x_ready, 1);
  endtask

  initial begin
    longint xs [81];
    longint sx [12];

    // reset values
    #2;
    check("rst_x_ready", x_ready, 1);
    check("rst_y_valid", y_valid, 0);
    check("rst_w_busy", w_busy, 0);
    check("rst_y_data", y_data, 0);
    check("rst_y_ovf", y_ovf, 0);
    tick();
    rst = 1'b0;
    tick();

    // all weights 1, x=127; a write at beat 10 and during hold is dropped
    foreach (mth[i]) mth[i] = 1;
    load_main();
    foreach (xs[i]) xs[i] = 127;
    run_vec("ones", xs, 1'b1, 10, 0, 999);
    check("ones_const", $signed(y_data), 10287);
    foreach (xs[i]) xs[i] = 1;
    run_vec("ones_readback", xs, 1'b0, -1, 0, 0);
    check("ones_readback_const", $signed(y_data), 81);

    // all weights -1, back-to-back vectors
    foreach (mth[i]) mth[i] = -1;
    load_main();
    foreach (xs[i]) xs[i] = 100;
    run_vec("neg100", xs, 1'b0, -1, 0, 0);
    check("neg100_const", $signed(y_data), -8100);
    foreach (xs[i]) xs[i] = 1;
    run_vec("neg1", xs, 1'b0, -1, 0, 0);
    check("neg1_const", $signed(y_data), -81);

    // wrap with overflow, then a clean vector clears the flag
    foreach (mth[i]) mth[i] = 2147483647;
    load_main();
    foreach (xs[i]) xs[i] = 127;
    run_vec("wrap", xs, 1'b0, -1, 0, 0);
    check("wrap_ovf_const", y_ovf, 1);
    foreach (mth[i]) mth[i] = 1;
    load_main();
    foreach (xs[i]) xs[i] = 1;
    run_vec("after_wrap", xs, 1'b0, -1, 0, 0);

    // writes coinciding with beat 0: old weight used by beat 0, new later
    foreach (mth[i]) mth[i] = longint'(int'($urandom_range(0, 2000)) - 1000);
    load_main();
    foreach (xs[i]) xs[i] = longint'($urandom_range(0, 127));
    run_vec("wr_b0_a0", xs, 1'b0, 0, 0, 777);
    run_vec("wr_b0_a3", xs, 1'b0, 0, 3, -555);
    run_vec("wr_b0_check", xs, 1'b0, -1, 0, 0);

    // reset mid-vector discards the partial sum, keeps the weights
    x_valid = 1'b1;
    for (int b = 0; b < 40; b++) begin
      x_data = 7'($urandom_range(0, 127));
      tick();
    end
    x_valid = 1'b0;
    check("mid_busy", w_busy, 1);
    rst = 1'b1;
    #2;
    check("mid_rst_x_ready", x_ready, 1);
    check("mid_rst_y_valid", y_valid, 0);
    check("mid_rst_w_busy", w_busy, 0);
    check("mid_rst_y_data", y_data, 0);
    check("mid_rst_y_ovf", y_ovf, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    run_vec("post_rst", xs, 1'b0, -1, 0, 0);

    // random vectors, mixing small and full-range weights
    for (int v = 0; v < 6; v++) begin
      foreach (mth[i])
        mth[i] = (v % 2 == 0) ? longint'(int'($urandom_range(0, 200000)) - 100000)
                              : longint'(int'($urandom()));
      load_main();
      foreach (xs[i]) xs[i] = longint'($urandom_range(0, 127));
      run_vec($sformatf("rand%0d", v), xs, v == 3, (v == 2) ? 5 : -1, 2, 4242);
    end

    // saturating 4-lane instance
    foreach (sth[i]) sth[i] = 32767;
    load_sat();
    foreach (sx[i]) sx[i] = 127;
    run_sat("sat_pos", sx);
    check("sat_pos_const", $signed(s_y_data), 32767);
    foreach (sth[i]) sth[i] = i;
    load_sat();
    foreach (sx[i]) sx[i] = 1;
    sx[10] = 127; sx[11] = 127;
    run_sat("sat_pad", sx);
    check("sat_pad_const", $signed(s_y_data), 45);
    foreach (sth[i]) sth[i] = -32768;
    load_sat();
    foreach (sx[i]) sx[i] = 127;
    run_sat("sat_neg", sx);
    for (int v = 0; v < 5; v++) begin
      foreach (sth[i]) sth[i] = longint'(int'($urandom_range(0, 65535)) - 32768);
      if (v < 2) foreach (sth[i]) sth[i] = sth[i] / 64;
      load_sat();
      foreach (sx[i]) sx[i] = longint'($urandom_range(0, 127));
      run_sat($sformatf("sat_rand%0d", v), sx);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/innerproduct_stream.md
# innerproduct_stream

Parametrised, sequential successor to the fixed 81-tap combinational inner-product blocks of the line-buffer logistic-regression datapath. It computes h' = Σ x[i]·θ[i] over N_FEAT features, consuming LANES features per beat through a valid/ready stream. Weights live in a runtime-writable register file rather than compile-time constants. The result is presented on a held valid/ready output with selectable saturate or wrap arithmetic and a sticky overflow flag. It sits between the line buffer (x source) and the sigmoid/threshold stage (y sink).

## Interface
- N_FEAT, 81, features per vector (≥1)
- LANES, 1, features consumed per beat (1..N_FEAT)
- XW, 7, pixel width, unsigned
- TW, 32, weight width, signed two's complement
- ACC_W, 32, accumulator/result width, signed
- SAT, 0, 1 = saturate on overflow, 0 = wrap modulo 2^ACC_W
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- w_we  in  1  weight write strobe
- w_addr  in  clog2(N_FEAT)  weight index; addresses ≥ N_FEAT ignored
- w_data  in  TW  weight value
- w_busy  out  1  high when writes are being dropped
- x_valid  in  1  input beat valid
- x_ready  out  1  input beat accepted when x_valid & x_ready
- x_data  in  LANES*XW  lane k in bits [k*XW +: XW] = feature beat*LANES+k
- y_valid  out  1  result valid
- y_ready  in  1  result consumed when y_valid & y_ready
- y_data  out  ACC_W  signed inner product
- y_ovf  out  1  overflow/clamp occurred during this vector

## Operation
- BEATS = ceil(N_FEAT/LANES); beat counter bcnt 0..BEATS-1, wraps to 0 after last beat.
- FSM: ACC (x_ready=1, y_valid=0) and HOLD (x_ready=0, y_valid=1).
- ACC, beat accepted: s = acc + Σ_k ({1'b0,x_k} signed × θ[bcnt*LANES+k]); lanes with index ≥ N_FEAT contribute 0 regardless of x_data. s evaluated at full precision.
- If s outside ACC_W signed range: ovf_sticky←1; acc ← clamp(s) if SAT=1, else s[ACC_W-1:0].
- Accepted beat with bcnt=BEATS-1: y_data ← updated acc, y_ovf ← updated ovf_sticky, acc←0, ovf_sticky←0, bcnt←0, → HOLD.
- HOLD: y_data/y_ovf stable; on y_valid & y_ready → ACC.
- Weight writes committed only when state=ACC and bcnt=0; else dropped. w_busy = (state=HOLD) | (bcnt≠0).
- A write and a beat-0 accept in the same cycle: beat uses the old weight; write commits at that edge.
- Weight file is not reset; must be loaded before first vector.

## Timing
- Reset (async assert, sync release): state=ACC, bcnt=0, acc=0, ovf_sticky=0, x_ready=1, w_busy=0, y_valid=0, y_data=0, y_ovf=0. Weight contents retained.
- Reset mid-vector discards partial sum; next accepted beat is feature 0.
- Throughput: one beat per cycle in ACC; x_ready combinational from state only (no dependency on x_valid).
- Latency: last beat accepted at edge t → y_valid=1 after edge t (visible in cycle t+1).
- Output handshake at edge u → x_ready=1 in cycle u+1; one bubble cycle per vector, so peak rate BEATS+1 cycles/vector.
- x_valid low: no state change. y_ready high while y_valid low: no effect.

## Test plan
- Default params, all θ=1, 81 beats x=127 → y_data=10287, y_ovf=0, y_valid one cycle after 81st accept.
- LANES=4 (21 beats), θ[i]=i, all x=1, lanes 1..3 of beat 20 driven 127 → y_data=3240 (padding lanes ignored).
- All θ=-1, x=100 → y_data=-8100; second back-to-back vector with x=1 → -81, y_ovf=0 both.
- ACC_W=16, θ=32767, x=127: SAT=1 → y_data=32767, y_ovf=1; SAT=0 → y_data=22481, y_ovf=1; following vector with θ=1, x=1 (reloaded) → y_ovf=0.
- y_ready held low 5 cycles → y_data stable, x_ready=0, w_busy=1; w_we at bcnt=10 is dropped (weight unchanged on readback via next vector result).
- rst pulsed after 40 beats → all outputs at reset values; full 81-beat vector afterwards gives correct result with pre-reset weights.
